uart_word_packer: RTL

UART_WORD_PACKER -- requirements
Module: uart_word_packer

---
 rtl/ac1_pkg.sv | 14 +
 rtl/packer_timeout_ctr.sv | 32 +++
 rtl/uart_word_packer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ac1_pkg.sv
// Shared constants and state type for the UART-to-DDR word packer.
package ac1_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 64;

  // EMPTY: no bytes held, FILL: 1..7 bytes held, STALL: full word waiting for output register
  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    STALL
  } packer_state_e;

endpackage

// File: rtl/packer_timeout_ctr.sv
// Idle-cycle counter for partial-word flushing; saturates one short of the limit so that
// expired stays asserted while a flush waits for the output register.
module packer_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic input_clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // Count idle cycles, restart on clear, hold at LAST
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires in the cycle that completes TIMEOUT_CYCLES idle cycles
  assign expired = run && (cnt_q == LAST);

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART bytes (first byte in LSBs) into 64-bit words for the DDR write port.
// Double buffered: assembly register plus output register.
// Optional macro PACKER_TIMEOUT_EN flushes a partial word after TIMEOUT_CYCLES idle cycles.
module uart_word_packer
  import ac1_pkg::*;
#(
  parameter int unsigned WORD_BYTES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_received,
  input  logic              data_rdy,
  input  logic              write_ready,
  input  logic              clear_ovf,
  output logic [WORD_W-1:0] write_data,
  output logic              write_valid,
  output logic [3:0]        write_len,
  output logic [3:0]        byte_count,
  output logic              overflow
);

  localparam logic [3:0] FULL = 4'(WORD_BYTES);

  packer_state_e     state_q, state_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_len_q, out_len_d;
  logic              ovf_q, ovf_d;

  logic              accept, out_free, drop, flush_req;
  logic [WORD_W-1:0] asm_new;

`ifdef PACKER_TIMEOUT_EN
  logic to_run, to_clear, to_expired;

  assign to_run   = (state_q == FILL) && !data_rdy;
  assign to_clear = data_rdy || (state_q != FILL);

  packer_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .input_clk(input_clk),
    .reset    (reset),
    .clear    (to_clear),
    .run      (to_run),
    .expired  (to_expired)
  );

  assign flush_req = to_expired;
`else
  assign flush_req = 1'b0;
`endif

  assign accept   = out_valid_q && write_ready;
  // Output register can take a word on this edge (empty, or draining now)
  assign out_free = !out_valid_q || accept;
  assign asm_new  = asm_q | (WORD_W'(data_received) << {cnt_q[2:0], 3'b000});

  // Next-state: byte assembly, word hand-off, overflow tracking
  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_len_d   = out_len_q;
    drop        = 1'b0;

    // Clearing on accept keeps write_data at 0 whenever write_valid is low
    if (accept) begin
      out_d       = '0;
      out_valid_d = 1'b0;
      out_len_d   = '0;
    end

    unique case (state_q)
      EMPTY, FILL: begin
        if (data_rdy) begin
          if (cnt_q == FULL - 4'd1) begin
            if (out_free) begin
              out_d       = asm_new;
              out_valid_d = 1'b1;
              out_len_d   = FULL;
              asm_d       = '0;
              cnt_d       = '0;
              state_d     = EMPTY;
            end else begin
              asm_d   = asm_new;
              cnt_d   = FULL;
              state_d = STALL;
            end
          end else begin
            asm_d   = asm_new;
            cnt_d   = cnt_q + 4'd1;
            state_d = FILL;
          end
        end else if (flush_req && out_free) begin
          out_d       = asm_q;
          out_valid_d = 1'b1;
          out_len_d   = cnt_q;
          asm_d       = '0;
          cnt_d       = '0;
          state_d     = EMPTY;
        end
      end
      STALL: begin
        if (out_free) begin
          out_d       = asm_q;
          out_valid_d = 1'b1;
          out_len_d   = FULL;
          // A byte arriving on the hand-off edge starts the next word
          if (data_rdy) begin
            asm_d   = WORD_W'(data_received);
            cnt_d   = 4'd1;
            state_d = FILL;
          end else begin
            asm_d   = '0;
            cnt_d   = '0;
            state_d = EMPTY;
          end
        end else if (data_rdy) begin
          drop = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Set wins over clear
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and data registers
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      asm_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_len_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_len_q   <= out_len_d;
      ovf_q       <= ovf_d;
    end
  end

  assign write_data  = out_q;
  assign write_valid = out_valid_q;
  assign write_len   = out_len_q;
  assign byte_count  = cnt_q;
  assign overflow    = ovf_q;

endmodule
